// File: rtl/regfile_arbiter.sv
// regfile_arbiter: serialises single read/write requests from the core (port 0)
// and the debug/loader port (port 1) onto the shared 4x8-bit register file.
// Each transaction walks IDLE -> ACCESS -> DONE; Ack pulses in DONE.
// Optional feature macro: REGARB_ROUND_ROBIN_EN (round-robin tie-break);
// when undefined, port 0 always wins a tie.
module regfile_arbiter (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic       Wr0,
  input  logic       Wr1,
  input  logic [1:0] Idx0,
  input  logic [1:0] Idx1,
  input  logic [7:0] WData0,
  input  logic [7:0] WData1,
  output logic       Ack0,
  output logic       Ack1,
  output logic [7:0] RData0,
  output logic [7:0] RData1,
  input  logic [7:0] RegOut,
  output logic       RegCE,
  output logic [3:0] RegNum,
  output logic [7:0] A
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       grant_port;
  logic       sel_wr;
  logic [1:0] sel_idx;
  logic [7:0] sel_wdata;

  logic       lat_port;
  logic       lat_wr;
  logic       regce_q;

`ifdef REGARB_ROUND_ROBIN_EN
  logic       last_winner;

  // Remember who was served last; reset to 1 so that port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (Reset) begin
      last_winner <= 1'b1;
    end else if (state == ACCESS) begin
      last_winner <= lat_port;
    end
  end

  // On a tie the port that was not served last wins
  always_comb begin
    grant_port = 1'b0;
    if (Req0 && Req1) begin
      grant_port = ~last_winner;
    end else if (Req1) begin
      grant_port = 1'b1;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting
  always_comb begin
    grant_port = 1'b0;
    if (!Req0 && Req1) begin
      grant_port = 1'b1;
    end
  end
`endif

  // Route the winning port's request fields toward the latch
  always_comb begin
    sel_wr    = Wr0;
    sel_idx   = Idx0;
    sel_wdata = WData0;
    if (grant_port) begin
      sel_wr    = Wr1;
      sel_idx   = Idx1;
      sel_wdata = WData1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: only leaving IDLE depends on the requests
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Req0 || Req1) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner in IDLE, drive the register file in ACCESS, ack in DONE
  always_ff @(posedge clk) begin
    if (Reset) begin
      lat_port <= 1'b0;
      lat_wr   <= 1'b0;
      regce_q  <= 1'b0;
      RegNum   <= 4'b0000;
      A        <= 8'h00;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      RData0   <= 8'h00;
      RData1   <= 8'h00;
    end else begin
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            lat_port <= grant_port;
            lat_wr   <= sel_wr;
            regce_q  <= sel_wr;
            RegNum   <= 4'b0001 << sel_idx;
            A        <= sel_wdata;
          end
        end
        ACCESS: begin
          RegNum  <= 4'b0000;
          regce_q <= 1'b0;
          if (lat_port) begin
            Ack1 <= 1'b1;
          end else begin
            Ack0 <= 1'b1;
          end
          if (!lat_wr) begin
            if (lat_port) begin
              RData1 <= RegOut;
            end else begin
              RData0 <= RegOut;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A reset arriving mid-access must suppress the write immediately
  assign RegCE = regce_q & ~Reset;

endmodule
